conv_encoder_frame: RTL and testbench
=====================================

// Module: conv_encoder_frame
// PURPOSE
//  Rate-1/2, K=3 convolutional encoder (generators 7/5 octal): the transmit-side counterpart of the
//  PISO -> Viterbi_decoding -> SIPO receive chain. Captures one parallel data word, encodes it MSB-first
//  one bit per cycle, streams 2-bit symbols (o_sym/o_valid) and packs them into a parallel codeword
//  (o_data/o_done) sized for the decoder-side PISO input.
// PARAMETERS
//  SIZE_DATA_IN   8        info bits per frame
//  SIZE_DATA_OUT  16       codeword width; must equal 2*SIZE_DATA_IN (elaboration $error otherwise)
//  G0             3'b111   generator for o_sym[1], bit order {u, s1, s2}
//  G1             3'b101   generator for o_sym[0], bit order {u, s1, s2}
// PORTS
//  i_clk     in   1              clock, all logic on rising edge
//  i_rst     in   1              synchronous reset, active-high
//  i_start   in   1              frame request; honoured only when o_ready=1
//  i_data    in   SIZE_DATA_IN   frame data, sampled on accepted i_start
//  o_ready   out  1              1 in IDLE only
//  o_sym     out  2              encoded symbol {c0, c1}
//  o_valid   out  1              o_sym qualifier, one symbol per cycle
//  o_data    out  SIZE_DATA_OUT  packed codeword; first symbol in [MSB:MSB-1]
//  o_done    out  1              1-cycle pulse: o_data complete
// BEHAVIOUR
//  - Reset (i_rst=1 at edge): state=IDLE, shift reg {s1,s2}=0, bit counter=0, o_sym=0, o_valid=0,
//    o_data=0, o_done=0, o_ready=1. Reset mid-frame aborts it; no o_done; partial o_data discarded.
//  - FSM: IDLE -> ENCODE on i_start (latch i_data, clear {s1,s2}, counter=0);
//    ENCODE -> DONE after symbol SIZE_DATA_IN-1 (-> TAIL instead when CONV_TAIL_EN);
//    TAIL -> DONE after 2 tail symbols; DONE -> IDLE unconditionally.
//  - ENCODE cycle k: u = data[SIZE_DATA_IN-1-k]; c0 = ^(G0 & {u,s1,s2}); c1 = ^(G1 & {u,s1,s2});
//    registered: o_sym={c0,c1}, o_valid=1, o_data[SIZE_DATA_OUT-1-2k -: 2]={c0,c1}; then s2<=s1, s1<=u.
//  - Timing (start accepted at edge 0): o_valid high on cycles 1..SIZE_DATA_IN; o_done=1 on cycle
//    SIZE_DATA_IN+1 with final o_data; back in IDLE (o_ready=1) cycle SIZE_DATA_IN+2.
//  - o_valid=0 and o_sym=0 outside symbol cycles. o_data cleared on accepted start, else held
//    until the next accepted start.
//  - i_start while o_ready=0 (ENCODE/TAIL/DONE) ignored, not queued; i_data changes ignored after capture.
//  - i_start and i_rst same cycle: reset wins.
//  - Counter width $clog2(SIZE_DATA_IN)+1; no wrap inside a frame.
// CONFIGURATION
//  CONV_TAIL_EN defined: after the last data symbol, 2 zero tail bits encoded in state TAIL; o_valid
//    stays high 2 extra cycles (cycles SIZE_DATA_IN+1..+2), trellis ends in state 00; tail symbols
//    appear on o_sym only, NOT in o_data; o_done moves to cycle SIZE_DATA_IN+3.
//  CONV_TAIL_EN undefined: TAIL state absent; frame ends unterminated; timing as in BEHAVIOUR.
// TESTING
//  1. i_data=8'hB0, start -> o_sym 11,10,00,01,01,11,00,00 on cycles 1..8; o_done cycle 9, o_data=16'hE170.
//  2. i_data=8'h80 -> o_data=16'hEC00; i_data=8'h00 -> o_data=16'h0000, o_valid still 8 cycles.
//  3. CONV_TAIL_EN, i_data=8'h01 -> o_data=16'h0003; tail o_sym 10,11 on cycles 9,10; o_done cycle 11.
//  4. i_start pulsed on cycles 3 and 9 of a frame -> ignored; one o_done only; o_ready=1 cycle 10.
//  5. i_rst on cycle 5 mid-frame -> next cycle o_valid=0, o_data=0, o_ready=1; no o_done; new start
//     with 8'hB0 again yields 16'hE170 (state cleared).
//  6. Loopback: random i_data through this block -> PISO -> Viterbi_decoding -> SIPO; recovered
//     byte equals i_data for 100 frames.

Source files
------------

// File: rtl/conv_encoder_frame.sv
// Rate-1/2 K=3 convolutional encoder: one parallel word in, MSB-first 2-bit symbols out, plus packed codeword.
// Optional trellis termination (two zero tail bits, o_sym only) is enabled with `define CONV_TAIL_EN.
module conv_encoder_frame #(
    parameter int         SIZE_DATA_IN  = 8,
    parameter int         SIZE_DATA_OUT = 16,
    parameter logic [2:0] G0            = 3'b111,
    parameter logic [2:0] G1            = 3'b101
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [SIZE_DATA_IN-1:0]  i_data,
    output logic                     o_ready,
    output logic [1:0]               o_sym,
    output logic                     o_valid,
    output logic [SIZE_DATA_OUT-1:0] o_data,
    output logic                     o_done
);

    localparam int CW = $clog2(SIZE_DATA_IN) + 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE_DATA_IN - 1);

    if (SIZE_DATA_OUT != 2 * SIZE_DATA_IN) begin : g_size_check
        $error("conv_encoder_frame: SIZE_DATA_OUT must equal 2*SIZE_DATA_IN");
    end

`ifdef CONV_TAIL_EN
    typedef enum logic [1:0] {IDLE, ENCODE, TAIL, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ENCODE, DONE} state_t;
`endif

    state_t                   state_q, state_d;
    logic [SIZE_DATA_IN-1:0]  data_q, data_d;
    logic                     s1_q, s1_d, s2_q, s2_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [1:0]               sym_q, sym_d;
    logic                     valid_q, valid_d;
    logic [SIZE_DATA_OUT-1:0] odata_q, odata_d;
    logic                     done_q, done_d;
    logic                     ready_q, ready_d;

    logic       u;
    logic [1:0] code;

    // Data word is shifted left so the current info bit is always the MSB (tail bits are zero)
    always_comb begin
        u    = (state_q == ENCODE) ? data_q[SIZE_DATA_IN-1] : 1'b0;
        code = {^(G0 & {u, s1_q, s2_q}), ^(G1 & {u, s1_q, s2_q})};
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        cnt_d   = cnt_q;
        sym_d   = '0;
        valid_d = 1'b0;
        odata_d = odata_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start && ready_q) begin
                    state_d = ENCODE;
                    data_d  = i_data;
                    s1_d    = 1'b0;
                    s2_d    = 1'b0;
                    cnt_d   = '0;
                    odata_d = '0;
                end
            end
            ENCODE: begin
                sym_d   = code;
                valid_d = 1'b1;
                // Shift-in packing lands symbol k at [OUT-1-2k -: 2] once all symbols are in
                odata_d = {odata_q[SIZE_DATA_OUT-3:0], code};
                data_d  = {data_q[SIZE_DATA_IN-2:0], 1'b0};
                s2_d    = s1_q;
                s1_d    = u;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
`ifdef CONV_TAIL_EN
                    state_d = TAIL;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef CONV_TAIL_EN
            TAIL: begin
                sym_d   = code;
                valid_d = 1'b1;
                s2_d    = s1_q;
                s1_d    = u;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // o_done is registered on leaving DONE, so readiness returns one cycle after the done pulse
        ready_d = (state_d == IDLE) && (state_q != DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            sym_q   <= '0;
            valid_q <= 1'b0;
            odata_q <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            valid_q <= valid_d;
            odata_q <= odata_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign o_ready = ready_q;
    assign o_sym   = sym_q;
    assign o_valid = valid_q;
    assign o_data  = odata_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_conv_encoder_frame.sv
// Directed self-checking bench for conv_encoder_frame (default build and CONV_TAIL_EN build).
module tb_conv_encoder_frame;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_data = '0;
    logic        o_ready;
    logic [1:0]  o_sym;
    logic        o_valid;
    logic [15:0] o_data;
    logic        o_done;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef CONV_TAIL_EN
    localparam int NVALID = 10;
`else
    localparam int NVALID = 8;
`endif
    localparam int DONE_CYC  = NVALID + 1;
    localparam int READY_CYC = NVALID + 2;

    logic [1:0]  sym_r   [0:15];
    logic        valid_r [0:15];
    logic        done_r  [0:15];
    logic        ready_r [0:15];
    logic [15:0] data_r  [0:15];

    conv_encoder_frame #(
        .SIZE_DATA_IN (8),
        .SIZE_DATA_OUT(16),
        .G0           (3'b111),
        .G1           (3'b101)
    ) dut (
        .i_clk  (clk),
        .i_rst  (i_rst),
        .i_start(i_start),
        .i_data (i_data),
        .o_ready(o_ready),
        .o_sym  (o_sym),
        .o_valid(o_valid),
        .o_data (o_data),
        .o_done (o_done)
    );

    always #5 clk = ~clk;

    // Starts a frame and records outputs on cycles 1..15; optional start pulses (pa, pb) and reset (rc)
    task automatic collect(input logic [7:0] d, input int pa, input int pb, input int rc,
                           input logic [7:0] alt);
        int waited = 0;
        while (o_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            n_checks++;
            $display("FAIL ready_timeout: o_ready=%b required 1", o_ready);
        end
        i_data  = d;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            sym_r[c]   = o_sym;
            valid_r[c] = o_valid;
            done_r[c]  = o_done;
            ready_r[c] = o_ready;
            data_r[c]  = o_data;
            i_start = (c == pa) || (c == pb);
            i_rst   = (c == rc);
            if (i_start) i_data = alt;
        end
        i_start = 1'b0;
        i_rst   = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        n_checks++;
        if ({o_ready, o_valid, o_sym, o_done, o_data} !== {1'b1, 1'b0, 2'b00, 1'b0, 16'h0000})
            $display("FAIL reset_state: got rdy=%b val=%b sym=%b done=%b data=%h required 1 0 00 0 0000",
                     o_ready, o_valid, o_sym, o_done, o_data);
        else n_pass++;
        i_rst = 1'b1; i_start = 1'b1; i_data = 8'hB0;
        @(negedge clk);
        i_rst = 1'b0; i_start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({o_ready, o_valid} !== 2'b10)
            $display("FAIL rst_beats_start: got rdy=%b val=%b required 1 0", o_ready, o_valid);
        else n_pass++;
    endtask

    task automatic test_encode_b0();
        logic [1:0] exp_sym [1:10];
        exp_sym = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        collect(8'hB0, 0, 0, 0, 8'h00);
        for (int c = 1; c <= NVALID; c++) begin
            n_checks++;
            if ({valid_r[c], sym_r[c]} !== {1'b1, exp_sym[c]})
                $display("FAIL b0_sym cycle %0d: got val=%b sym=%b required 1 %b",
                         c, valid_r[c], sym_r[c], exp_sym[c]);
            else n_pass++;
        end
        n_checks++;
        if ({done_r[DONE_CYC], valid_r[DONE_CYC], sym_r[DONE_CYC], data_r[DONE_CYC]} !==
            {1'b1, 1'b0, 2'b00, 16'hE170})
            $display("FAIL b0_done: got done=%b val=%b sym=%b data=%h required 1 0 00 e170",
                     done_r[DONE_CYC], valid_r[DONE_CYC], sym_r[DONE_CYC], data_r[DONE_CYC]);
        else n_pass++;
        n_checks++;
        if ({ready_r[DONE_CYC], ready_r[READY_CYC], done_r[READY_CYC], done_r[NVALID]} !== 4'b0100)
            $display("FAIL b0_ready: got rdy@done=%b rdy@next=%b done@next=%b done@last=%b required 0 1 0 0",
                     ready_r[DONE_CYC], ready_r[READY_CYC], done_r[READY_CYC], done_r[NVALID]);
        else n_pass++;
        n_checks++;
        if (data_r[15] !== 16'hE170)
            $display("FAIL b0_hold: got o_data=%h required e170", data_r[15]);
        else n_pass++;
    endtask

    task automatic test_patterns();
        int nv;
        collect(8'h80, 0, 0, 0, 8'h00);
        n_checks++;
        if ({done_r[DONE_CYC], data_r[DONE_CYC]} !== {1'b1, 16'hEC00})
            $display("FAIL p80: got done=%b data=%h required 1 ec00", done_r[DONE_CYC], data_r[DONE_CYC]);
        else n_pass++;
        collect(8'h00, 0, 0, 0, 8'h00);
        n_checks++;
        if ({done_r[DONE_CYC], data_r[DONE_CYC]} !== {1'b1, 16'h0000})
            $display("FAIL p00: got done=%b data=%h required 1 0000", done_r[DONE_CYC], data_r[DONE_CYC]);
        else n_pass++;
        nv = 0;
        for (int c = 1; c <= 15; c++) if (valid_r[c] === 1'b1) nv++;
        n_checks++;
        if (nv !== NVALID)
            $display("FAIL p00_valid_count: got %0d required %0d", nv, NVALID);
        else n_pass++;
    endtask

`ifdef CONV_TAIL_EN
    task automatic test_tail();
        collect(8'h01, 0, 0, 0, 8'h00);
        n_checks++;
        if ({valid_r[9], sym_r[9], valid_r[10], sym_r[10]} !== {1'b1, 2'b10, 1'b1, 2'b11})
            $display("FAIL tail_syms: got %b/%b %b/%b required 1/10 1/11",
                     valid_r[9], sym_r[9], valid_r[10], sym_r[10]);
        else n_pass++;
        n_checks++;
        if ({done_r[10], done_r[11], data_r[11]} !== {1'b0, 1'b1, 16'h0003})
            $display("FAIL tail_done: got done10=%b done11=%b data=%h required 0 1 0003",
                     done_r[10], done_r[11], data_r[11]);
        else n_pass++;
    endtask
`endif

    task automatic test_start_ignored();
        int nd;
        int nv;
        collect(8'hB0, 3, DONE_CYC, 0, 8'hFF);
        nd = 0;
        for (int c = 1; c <= 15; c++) if (done_r[c] === 1'b1) nd++;
        n_checks++;
        if (nd !== 1) $display("FAIL ign_done_count: got %0d required 1", nd);
        else n_pass++;
        n_checks++;
        if (data_r[DONE_CYC] !== 16'hE170)
            $display("FAIL ign_data: got %h required e170", data_r[DONE_CYC]);
        else n_pass++;
        n_checks++;
        if (ready_r[READY_CYC] !== 1'b1)
            $display("FAIL ign_ready: got %b required 1", ready_r[READY_CYC]);
        else n_pass++;
        nv = 0;
        for (int c = DONE_CYC; c <= 15; c++) if (valid_r[c] === 1'b1) nv++;
        n_checks++;
        if (nv !== 0) $display("FAIL ign_no_queue: got %0d valid cycles after frame required 0", nv);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int nd;
        collect(8'hB0, 0, 0, 5, 8'h00);
        n_checks++;
        if ({valid_r[6], data_r[6], ready_r[6]} !== {1'b0, 16'h0000, 1'b1})
            $display("FAIL midrst_state: got val=%b data=%h rdy=%b required 0 0000 1",
                     valid_r[6], data_r[6], ready_r[6]);
        else n_pass++;
        nd = 0;
        for (int c = 6; c <= 15; c++) if (done_r[c] === 1'b1 || valid_r[c] === 1'b1) nd++;
        n_checks++;
        if (nd !== 0) $display("FAIL midrst_quiet: got %0d active cycles required 0", nd);
        else n_pass++;
        collect(8'hB0, 0, 0, 0, 8'h00);
        n_checks++;
        if ({done_r[DONE_CYC], data_r[DONE_CYC]} !== {1'b1, 16'hE170})
            $display("FAIL midrst_restart: got done=%b data=%h required 1 e170",
                     done_r[DONE_CYC], data_r[DONE_CYC]);
        else n_pass++;
    endtask

    // Symbol inverse: c1 = u ^ s2, so each info bit is c1 xor the bit two steps earlier
    task automatic test_loopback();
        logic [7:0] d;
        logic [7:0] rec;
        logic       um1;
        logic       um2;
        logic       u;
        for (int f = 0; f < 100; f++) begin
            d = 8'($urandom_range(0, 255));
            collect(d, 0, 0, 0, 8'h00);
            um1 = 1'b0;
            um2 = 1'b0;
            rec = '0;
            for (int k = 0; k < 8; k++) begin
                u   = sym_r[k + 1][0] ^ um2;
                rec = {rec[6:0], u};
                um2 = um1;
                um1 = u;
            end
            n_checks++;
            if (rec !== d || done_r[DONE_CYC] !== 1'b1)
                $display("FAIL loopback frame %0d: got %h (done=%b) required %h",
                         f, rec, done_r[DONE_CYC], d);
            else n_pass++;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_encode_b0();
        test_patterns();
`ifdef CONV_TAIL_EN
        test_tail();
`endif
        test_start_ignored();
        test_reset_mid_frame();
        test_loopback();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
